instruction_memory: RTL and testbench
=====================================

INSTRUCTION_MEMORY -- requirements
Module: instruction_memory

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 64, number of 32-bit words stored; power of two, minimum 4.
REQ-002 SHALL have parameter ERASED_WORD, default 32'hFFFF_FFFF, value of an unprogrammed or out-of-range word.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port addr  input  32  byte address for instruction fetch.
REQ-006 SHALL have port rd_instr  output  32  instruction word at addr.
REQ-007 SHALL have port prog_we  input  1  program-port write strobe.
REQ-008 SHALL have port prog_addr  input  32  program-port byte address.
REQ-009 SHALL have port prog_data  input  32  program-port write data.
REQ-010 SHALL have port prog_be  input  4  byte enables; bit n covers prog_data[8n+7:8n].
REQ-011 SHALL have port addr_err  output  1  fetch-address fault flag, present only with INSTR_MEM_ADDR_CHK_EN.

Function
REQ-012 SHALL store DEPTH_WORDS little-endian 32-bit words; word index = addr[log2(DEPTH_WORDS)+1:2].
REQ-013 SHALL drive rd_instr combinationally from addr, zero cycles latency, no clock dependency.
REQ-014 SHALL ignore addr[1:0] for the read; any byte address returns its containing aligned word.
REQ-015 SHALL return ERASED_WORD when addr >= 4*DEPTH_WORDS; no aliasing onto low words.
REQ-016 SHALL hold every word at ERASED_WORD from power-up (time zero), before any reset or write.
REQ-017 SHALL write, on rising clk with rst_n=1 and prog_we=1, each byte lane whose prog_be bit is set into word prog_addr[log2(DEPTH_WORDS)+1:2]; other lanes unchanged.
REQ-018 SHALL ignore prog_addr[1:0] and SHALL drop writes with prog_addr >= 4*DEPTH_WORDS.
REQ-019 SHALL show old data on rd_instr for a same-word read during the write cycle and new data immediately after the edge.
REQ-020 SHALL treat prog_be=4'b0000 with prog_we=1 as a no-op.

Reset
REQ-021 SHALL, on rising clk with rst_n=0, set every word to ERASED_WORD in that single cycle.
REQ-022 SHALL ignore prog_we while rst_n=0; reset wins over simultaneous write.
REQ-023 SHALL keep rd_instr combinational during reset; after the reset edge it reads ERASED_WORD for all addresses.
REQ-024 SHALL clear addr_err only combinationally; it has no stored state and no reset value of its own.

Configuration
REQ-025 SHALL compile addr_err and its check logic only when macro INSTR_MEM_ADDR_CHK_EN is defined.
REQ-026 With INSTR_MEM_ADDR_CHK_EN: addr_err=1 combinationally when addr[1:0]!=0 or addr >= 4*DEPTH_WORDS, else 0; rd_instr behaviour unchanged.
REQ-027 Without INSTR_MEM_ADDR_CHK_EN: port addr_err SHALL be absent; all other behaviour identical.

Structure
REQ-028 SHALL place ERASED_WORD default, XLEN=32, and a word-index-width function in shared package riscv_pkg.
REQ-029 SHALL be a single module; no sub-module; storage inferred as a register array with asynchronous read.

Verification
REQ-030 Power-up, no reset, no writes: addr 0..31 stepped each 10 ns -> rd_instr=32'hFFFF_FFFF every step.
REQ-031 Write prog_addr=0x8, prog_data=0x00500093, prog_be=4'hF -> addr 0x8, 0x9, 0xA, 0xB all read 0x00500093; addr 0x4 reads 0xFFFFFFFF.
REQ-032 After reset, write 0x12345678 to 0x10 with prog_be=4'b0011 -> addr 0x10 reads 0xFFFF5678.
REQ-033 Program words 0x0 and 0xFC, then rst_n=0 one cycle with prog_we=1 to 0x4 -> all addresses read 0xFFFFFFFF, 0x4 not written.
REQ-034 DEPTH_WORDS=64: write 0xDEADBEEF to 0xFC and to 0x100 -> 0xFC reads 0xDEADBEEF, 0x0 and 0x100 read 0xFFFFFFFF.
REQ-035 With INSTR_MEM_ADDR_CHK_EN: addr 0x0 -> addr_err=0; 0x3 -> 1; 0x100 -> 1; rd_instr per REQ-014/015.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V constants used by the instruction memory.
// Provides XLEN, the erased-flash word value and a word-index-width helper.
// Contains only types, constants and functions; it has no ports or state.
package riscv_pkg;

  localparam int XLEN = 32;

  // Value that an unprogrammed (or nonexistent) instruction word reads as.
  localparam logic [XLEN-1:0] ERASED_WORD_DEFAULT = 32'hFFFF_FFFF;

  // Number of address bits needed to select one of `depth` words.
  function automatic int word_idx_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/instruction_memory.sv
// Instruction memory: DEPTH_WORDS x 32-bit little-endian words, byte-lane programmable.
// Latency: fetch read is combinational (0 cycles); program writes and reset land on rising clk.
// Backpressure: none; writes always accepted, out-of-range writes are dropped.
//
// Ports:
//   clk        single clock
//   rst_n      synchronous active-low reset, erases every word in one cycle
//   addr       fetch byte address; rd_instr is the containing aligned word
//   rd_instr   fetched word, ERASED_WORD when addr is beyond the array
//   prog_we    program write strobe
//   prog_addr  program byte address (low two bits ignored)
//   prog_data  program write data
//   prog_be    per-byte write enables, bit n covers prog_data[8n+7:8n]
//   addr_err   misaligned / out-of-range fetch flag, only when INSTR_MEM_ADDR_CHK_EN is defined
module instruction_memory
  import riscv_pkg::*;
#(
  parameter int              DEPTH_WORDS = 64,
  parameter logic [XLEN-1:0] ERASED_WORD = ERASED_WORD_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] addr,
  input  logic            prog_we,
  input  logic [XLEN-1:0] prog_addr,
  input  logic [XLEN-1:0] prog_data,
  input  logic [3:0]      prog_be,
`ifdef INSTR_MEM_ADDR_CHK_EN
  output logic            addr_err,
`endif
  output logic [XLEN-1:0] rd_instr
);

  localparam int IDX_W = word_idx_w(DEPTH_WORDS);

  // Storage powers up erased so reads are valid before the first reset.
  logic [XLEN-1:0] mem_q [DEPTH_WORDS] = '{default: ERASED_WORD};
  logic [XLEN-1:0] mem_d [DEPTH_WORDS];

  logic [IDX_W-1:0] fetch_idx;
  logic             fetch_in_range;
  logic [IDX_W-1:0] prog_idx;
  logic             prog_in_range;

  // An address is in range only if every bit above the word index is zero;
  // this keeps high addresses from aliasing onto low words.
  assign fetch_idx      = addr[IDX_W+1:2];
  assign fetch_in_range = (addr[XLEN-1:IDX_W+2] == '0);
  assign prog_idx       = prog_addr[IDX_W+1:2];
  assign prog_in_range  = (prog_addr[XLEN-1:IDX_W+2] == '0);

  // Byte-offset bits never select data.
  logic unused_byte_offsets;
  assign unused_byte_offsets = ^{addr[1:0], prog_addr[1:0]};

  // Asynchronous read of the current (pre-edge) contents: a same-word read
  // during a write cycle sees the old word until the clock edge.
  assign rd_instr = fetch_in_range ? mem_q[fetch_idx] : ERASED_WORD;

`ifdef INSTR_MEM_ADDR_CHK_EN
  assign addr_err = (addr[1:0] != 2'b00) || !fetch_in_range;
`endif

  // Next-state: merge enabled byte lanes into the addressed word.
  always_comb begin
    mem_d = mem_q;
    if (prog_we && prog_in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (prog_be[b]) begin
          mem_d[prog_idx][8*b +: 8] = prog_data[8*b +: 8];
        end
      end
    end
  end

  // Reset takes priority over any simultaneous program write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem_q[i] <= ERASED_WORD;
      end
    end else begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: tb/tb_instruction_memory.sv
// Self-checking bench for instruction_memory (DEPTH_WORDS=64).
// A word-array model tracks expected contents; every negedge compares the DUT
// read port against it, and directed reads pin literal expected values.
module tb_instruction_memory;

  localparam int DEPTH = 64;
  localparam logic [31:0] ERASED = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] addr = 32'h0;
  logic        prog_we = 1'b0;
  logic [31:0] prog_addr = 32'h0;
  logic [31:0] prog_data = 32'h0;
  logic [3:0]  prog_be = 4'h0;
  logic [31:0] rd_instr;
`ifdef INSTR_MEM_ADDR_CHK_EN
  logic        addr_err;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  instruction_memory #(
    .DEPTH_WORDS(DEPTH),
    .ERASED_WORD(ERASED)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .addr     (addr),
    .prog_we  (prog_we),
    .prog_addr(prog_addr),
    .prog_data(prog_data),
    .prog_be  (prog_be),
`ifdef INSTR_MEM_ADDR_CHK_EN
    .addr_err (addr_err),
`endif
    .rd_instr (rd_instr)
  );

  // ---------------- behavioural model ----------------
  logic [31:0] model [DEPTH] = '{default: 32'hFFFF_FFFF};

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (a >= 32'(4 * DEPTH)) return ERASED;
    return model[a / 4];
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] w;
    w = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
    return w;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) model[i] <= ERASED;
    end else if (prog_we && prog_addr < 32'(4 * DEPTH)) begin
      model[prog_addr / 4] <= merge(model[prog_addr / 4], prog_data, prog_be);
    end
  end

  // ---------------- continuous compare ----------------
  always @(negedge clk) begin
    vectors++;
    if (rd_instr !== m_read(addr)) begin
      miscompares++;
      $display("FAIL model_rd addr=%h got=%h exp=%h", addr, rd_instr, m_read(addr));
    end
`ifdef INSTR_MEM_ADDR_CHK_EN
    vectors++;
    if (addr_err !== ((addr[1:0] != 2'b00) || (addr >= 32'(4 * DEPTH)))) begin
      miscompares++;
      $display("FAIL model_err addr=%h got=%b", addr, addr_err);
    end
`endif
  end

  // ---------------- directed helpers ----------------
  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
    @(posedge clk); #2;
    addr = a;
    #1;
    check(nm, rd_instr, exp);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    @(posedge clk); #2;
    prog_we = 1'b1; prog_addr = a; prog_data = d; prog_be = be;
    @(posedge clk); #2;
    prog_we = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Before any clock edge: erased from time zero.
    #1;
    check("powerup_t0", rd_instr, 32'hFFFF_FFFF);

    // Power-up sweep, no reset, no writes.
    for (int a = 0; a < 32; a++) rd(32'(a), 32'hFFFF_FFFF, "powerup_sweep");

    // Full-word write; read old data during the write cycle, new right after.
    @(posedge clk); #2;
    prog_we = 1'b1; prog_addr = 32'h8; prog_data = 32'h0050_0093; prog_be = 4'hF;
    addr = 32'h8;
    #1;
    check("old_during_write", rd_instr, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    check("new_after_edge", rd_instr, 32'h0050_0093);
    #1;
    prog_we = 1'b0;
    rd(32'h8, 32'h0050_0093, "full_wr_8");
    rd(32'h9, 32'h0050_0093, "full_wr_9");
    rd(32'hA, 32'h0050_0093, "full_wr_a");
    rd(32'hB, 32'h0050_0093, "full_wr_b");
    rd(32'h4, 32'hFFFF_FFFF, "neighbour_4");

    // Reset, then partial byte-lane writes.
    @(posedge clk); #2; rst_n = 1'b0;
    @(posedge clk); #2; rst_n = 1'b1;
    rd(32'h8, 32'hFFFF_FFFF, "reset_clears_8");
    wr(32'h10, 32'h1234_5678, 4'b0011);
    rd(32'h10, 32'hFFFF_5678, "be_0011");
    wr(32'h10, 32'h0000_0000, 4'b0000);
    rd(32'h10, 32'hFFFF_5678, "be_0000_noop");
    wr(32'h13, 32'hAABB_CCDD, 4'b1100);
    rd(32'h10, 32'hAABB_5678, "prog_low_bits_ignored");
    wr(32'h14, 32'h0102_0304, 4'b0100);
    rd(32'h16, 32'hFF02_FFFF, "be_0100");

    // Reset wins over simultaneous write and clears everything.
    wr(32'h0,  32'h1111_1111, 4'hF);
    wr(32'hFC, 32'h2222_2222, 4'hF);
    rd(32'h0,  32'h1111_1111, "pre_reset_0");
    rd(32'hFC, 32'h2222_2222, "pre_reset_fc");
    @(posedge clk); #2;
    rst_n = 1'b0; prog_we = 1'b1; prog_addr = 32'h4; prog_data = 32'h3333_3333; prog_be = 4'hF;
    @(posedge clk); #2;
    rst_n = 1'b1; prog_we = 1'b0;
    rd(32'h0,  32'hFFFF_FFFF, "post_reset_0");
    rd(32'h4,  32'hFFFF_FFFF, "post_reset_4_not_written");
    rd(32'hFC, 32'hFFFF_FFFF, "post_reset_fc");
    for (int w = 0; w < DEPTH; w++) rd(32'(4 * w + 1), 32'hFFFF_FFFF, "post_reset_sweep");

    // Boundary: last word written, out-of-range write dropped, no aliasing.
    wr(32'hFC,  32'hDEAD_BEEF, 4'hF);
    wr(32'h100, 32'hDEAD_BEEF, 4'hF);
    rd(32'hFC,  32'hDEAD_BEEF, "last_word");
    rd(32'hFF,  32'hDEAD_BEEF, "last_word_byte3");
    rd(32'h0,   32'hFFFF_FFFF, "no_alias_0");
    rd(32'h100, 32'hFFFF_FFFF, "oob_100");
    rd(32'hFFFF_FFFC, 32'hFFFF_FFFF, "oob_top");
    wr(32'h8000_0000, 32'h0BAD_0BAD, 4'hF);
    rd(32'h0,   32'hFFFF_FFFF, "high_write_dropped");

    // Distinct pattern per word; model compare checks each cycle of the sweep.
    for (int w = 0; w < 16; w++) wr(32'(4 * w), {4{8'(w + 8'h40)}}, 4'hF);
    rd(32'h0,  32'h4040_4040, "pattern_w0");
    rd(32'h3C, 32'h4F4F_4F4F, "pattern_w15");
    for (int w = 0; w < 20; w++) rd(32'(4 * w + 2), m_read(32'(4 * w)), "pattern_sweep");

`ifdef INSTR_MEM_ADDR_CHK_EN
    addr = 32'h0;   #1; check("err_0",   {31'b0, addr_err}, 32'h0);
    addr = 32'h3;   #1; check("err_3",   {31'b0, addr_err}, 32'h1);
    addr = 32'h100; #1; check("err_100", {31'b0, addr_err}, 32'h1);
    addr = 32'hFC;  #1; check("err_fc",  {31'b0, addr_err}, 32'h0);
`endif

    @(posedge clk); #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
